// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, load/store
// widths, FSM states, trap causes and the reused datapath helper units.
package rv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_MISALIGN = 2'd2,
    TRAP_ECALL    = 2'd3
  } trap_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: imm = {{20{ir[31]}}, ir[31:20]};
      STORE:       imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      BRANCH:      imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      LUI, AUIPC:  imm = {ir[31:12], 12'b0};
      JAL:         imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:     imm = '0;
    endcase
    return imm;
  endfunction

  // Only OP/OP-IMM select an operation; every other class needs an add.
  function automatic alu_op_t alu_control(input logic [6:0] opcode, input logic [2:0] f3,
                                          input logic f7b5);
    alu_op_t op;
    op = ALU_ADD;
    if (opcode == OP || opcode == OP_IMM) begin
      case (f3)
        3'b000:  op = (opcode == OP && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] y;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
    return y;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane steering for the shared memory port: store replication and
// strobes, load lane extraction with extension, and alignment checking.
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = load_word >> {addr[1:0], 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'b0, shifted[7:0]};
      F3_HU:   load_data = {16'b0, shifted[15:0]};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multi_cycle_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB control FSM sharing one
// ready/valid memory port between instruction and data accesses.
module rv_multi_cycle_core
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  state_t      state_q, state_d;
  trap_t       trap_q;
  logic [31:0] pc, ir, a_reg, b_reg, imm_reg, alu_reg, mdr;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        legal, is_load, is_store, is_branch, is_jal, is_jalr, is_system;
  logic [31:0] alu_a, alu_b, alu_y, pc_plus4, lsu_addr;
  logic [31:0] lsu_wdata, lsu_load_data, rd_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_misaligned, rd_wen, req_int;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign f3        = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign is_load   = (opcode == LOAD);
  assign is_store  = (opcode == STORE);
  assign is_branch = (opcode == BRANCH);
  assign is_jal    = (opcode == JAL);
  assign is_jalr   = (opcode == JALR);
  assign is_system = (opcode == SYSTEM);
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    case (opcode)
      LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign alu_a = (opcode == AUIPC || is_jal) ? pc : (opcode == LUI) ? '0 : a_reg;
  assign alu_b = (opcode == OP || is_branch) ? b_reg : imm_reg;
  assign alu_y = alu(alu_control(opcode, f3, ir[30]), alu_a, alu_b);

  // EXEC checks alignment on the freshly computed address; MEM uses the latched one.
  assign lsu_addr = (state_q == EXEC) ? alu_y : alu_reg;

  rv_lsu_align u_lsu (
    .funct3     (f3),
    .addr       (lsu_addr),
    .store_data (b_reg),
    .load_word  (mem_rdata),
    .wdata      (lsu_wdata),
    .wstrb      (lsu_wstrb),
    .load_data  (lsu_load_data),
    .misaligned (lsu_misaligned)
  );

  always_comb begin
    state_d   = state_q;
    req_int   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {pc[31:2], 2'b00};
    mem_wdata = '0;
    mem_wstrb = '0;
    retire    = 1'b0;
    case (state_q)
      FETCH: begin
        req_int = 1'b1;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (!legal || (is_system && HALT_ON_ECALL)) state_d = HALT;
        else                                          state_d = EXEC;
      end
      EXEC: begin
        if (is_branch) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_load || is_store) begin
          state_d = lsu_misaligned ? HALT : MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        req_int  = 1'b1;
        mem_addr = alu_reg;
        if (is_store) begin
          mem_we    = 1'b1;
          mem_wdata = lsu_wdata;
          mem_wstrb = lsu_wstrb;
        end
        if (mem_ready) begin
          retire  = is_store;
          state_d = is_store ? FETCH : WB;
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: ;
    endcase
  end

  // State already sits at FETCH during reset, so the request is masked by rst itself.
  assign mem_req    = req_int & ~rst;
  assign halted     = (state_q == HALT);
  assign trap_cause = trap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      trap_q  <= TRAP_NONE;
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_reg <= '0;
      mdr     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a_reg   <= regs[rs1];
          b_reg   <= regs[rs2];
          imm_reg <= imm_gen(ir);
          if (!legal)                              trap_q <= TRAP_ILLEGAL;
          else if (is_system && HALT_ON_ECALL)     trap_q <= TRAP_ECALL;
        end
        EXEC: begin
          alu_reg <= alu_y;
          if (is_branch)
            pc <= branch_taken(f3, a_reg, b_reg) ? pc + imm_reg : pc_plus4;
          if ((is_load || is_store) && lsu_misaligned) trap_q <= TRAP_MISALIGN;
        end
        MEM: begin
          if (mem_ready) begin
            if (is_store) pc  <= pc_plus4;
            else          mdr <= lsu_load_data;
          end
        end
        WB: pc <= is_jal ? alu_reg : is_jalr ? {alu_reg[31:1], 1'b0} : pc_plus4;
        default: ;
      endcase
    end
  end

  assign rd_wen   = (state_q == WB) && (rd != 5'd0) && !is_system;
  assign rd_wdata = is_load ? mdr : (is_jal || is_jalr) ? pc_plus4 : alu_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_wen) begin
      regs[rd] <= rd_wdata;
    end
  end

endmodule

// File: tb/tb_rv_multi_cycle_core.sv
// Directed bench for rv_multi_cycle_core: table of ALU vectors plus
// hand-written reset, backpressure, load/store, branch and trap sequences.
module tb_rv_multi_cycle_core;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_OPI = 7'b0010011, T_LUI = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111, T_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  trap_cause;

  logic [31:0] mem [512];

  int checks = 0;
  int failures = 0;

  rv_multi_cycle_core #(.RESET_PC(32'h0000_0100), .HALT_ON_ECALL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .retire     (retire),
    .halted     (halted),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:2]];

  // Per-run trace: cycle count, retire cycles, read addresses and stores.
  int unsigned cyc, n_ret, n_rd, n_st;
  int unsigned ret_cyc [16];
  logic [31:0] rd_log [32];
  logic [31:0] st_addr [8];
  logic [31:0] st_data [8];
  logic [3:0]  st_strb [8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; n_ret <= 0; n_rd <= 0; n_st <= 0;
    end else begin
      cyc <= cyc + 1;
      if (retire && n_ret < 16) begin
        ret_cyc[n_ret] <= cyc;
        n_ret <= n_ret + 1;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          if (n_st < 8) begin
            st_addr[n_st] <= mem_addr;
            st_data[n_st] <= mem_wdata;
            st_strb[n_st] <= mem_wstrb;
            n_st <= n_st + 1;
          end
        end else if (n_rd < 32) begin
          rd_log[n_rd] <= mem_addr;
          n_rd <= n_rd + 1;
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[10:2]] = w;
  endtask

  task automatic begin_test();
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 32'hFFFF_FFFF;
    mem[0] = 32'h0000_8000;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int i;
    for (i = 0; i < 300 && !halted; i++) @(negedge clk);
    chk({name, "_halted"}, {31'b0, halted}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic [31:0] instr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int unsigned quiet;

    vecs[0]  = '{"add",   12'h005, 12'h005, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0000_000A};
    vecs[1]  = '{"sub",   12'h003, 12'h005, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'hFFFF_FFFE};
    vecs[2]  = '{"slt",   12'hFFF, 12'h001, enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'h0000_0001};
    vecs[3]  = '{"sltu",  12'hFFF, 12'h001, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd3), 32'h0000_0000};
    vecs[4]  = '{"xor",   12'h0F0, 12'h0FF, enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3), 32'h0000_000F};
    vecs[5]  = '{"sll",   12'h003, 12'h004, enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd3), 32'h0000_0030};
    vecs[6]  = '{"srl",   12'hFF0, 12'h01C, enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd3), 32'h0000_000F};
    vecs[7]  = '{"sra",   12'hFF0, 12'h002, enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 32'hFFFF_FFFC};
    vecs[8]  = '{"or",    12'h500, 12'h0A0, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3), 32'h0000_05A0};
    vecs[9]  = '{"and",   12'h0F0, 12'h03C, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'h0000_0030};
    vecs[10] = '{"addi",  12'h005, 12'h000, enc_i(12'hFF9, 5'd1, 3'd0, 5'd3, T_OPI), 32'hFFFF_FFFE};
    vecs[11] = '{"srai",  12'hF00, 12'h000, enc_i(12'h404, 5'd1, 3'd5, 5'd3, T_OPI), 32'hFFFF_FFF0};
    vecs[12] = '{"lui",   12'h000, 12'h000, {20'hABCDE, 5'd3, T_LUI},              32'hABCD_E000};
    vecs[13] = '{"auipc", 12'h000, 12'h000, {20'h00001, 5'd3, T_AUIPC},            32'h0000_1108};
    vecs[14] = '{"sltiu", 12'h000, 12'h000, enc_i(12'h001, 5'd1, 3'd3, 5'd3, T_OPI), 32'h0000_0001};
    vecs[15] = '{"andi",  12'hFFF, 12'h000, enc_i(12'h0FF, 5'd1, 3'd7, 5'd3, T_OPI), 32'h0000_00FF};

    // Reset mid-fetch, then a fetch stalled three cycles.
    begin_test();
    put(32'h100, enc_i(12'h007, 5'd0, 3'd0, 5'd1, T_OPI));
    put(32'h104, enc_s(12'h000, 5'd1, 5'd0, 3'd2));
    mem_ready = 1'b0;
    release_rst();
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_req_low", {31'b0, mem_req}, 32'd0);
    chk("rst_halted_low", {31'b0, halted}, 32'd0);
    chk("rst_trap_zero", {30'b0, trap_cause}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_req", {31'b0, mem_req}, 32'd1);
      chk("stall_addr", mem_addr, 32'h0000_0100);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    wait_halt("stall");
    chk("stall_retire_cycle", ret_cyc[0], 32'd6);
    chk("stall_store_data", st_data[0], 32'd7);

    // Two ALU instructions and a store with zero-wait memory.
    begin_test();
    put(32'h100, enc_i(12'h005, 5'd0, 3'd0, 5'd1, T_OPI));
    put(32'h104, enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2));
    put(32'h108, enc_s(12'h000, 5'd2, 5'd0, 3'd2));
    release_rst();
    wait_halt("alu");
    chk("alu_first_retire", ret_cyc[0], 32'd3);
    chk("alu_retire_gap", ret_cyc[1] - ret_cyc[0], 32'd4);
    chk("store_retire_gap", ret_cyc[2] - ret_cyc[1], 32'd4);
    chk("alu_x2", st_data[0], 32'd10);
    chk("alu_trap", {30'b0, trap_cause}, 32'd1);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req || retire) quiet++;
    end
    chk("halt_quiet", quiet, 32'd0);

    // Table-driven ALU vectors: operands via ADDI, result stored by SW.
    for (int v = 0; v < 16; v++) begin
      begin_test();
      put(32'h100, enc_i(vecs[v].a, 5'd0, 3'd0, 5'd1, T_OPI));
      put(32'h104, enc_i(vecs[v].b, 5'd0, 3'd0, 5'd2, T_OPI));
      put(32'h108, vecs[v].instr);
      put(32'h10C, enc_s(12'h000, 5'd3, 5'd0, 3'd2));
      release_rst();
      wait_halt(vecs[v].name);
      chk({vecs[v].name, "_result"}, st_data[0], vecs[v].exp);
      chk({vecs[v].name, "_retires"}, n_ret, 32'd4);
    end

    // Byte/half stores and loads with lane steering and extension.
    begin_test();
    put(32'h100, enc_i(12'h0AB, 5'd0, 3'd0, 5'd2, T_OPI));
    put(32'h104, enc_s(12'h001, 5'd2, 5'd0, 3'd0));
    put(32'h108, enc_i(12'h001, 5'd0, 3'd0, 5'd3, T_LOAD));
    put(32'h10C, enc_s(12'h004, 5'd3, 5'd0, 3'd2));
    put(32'h110, enc_i(12'h001, 5'd0, 3'd4, 5'd4, T_LOAD));
    put(32'h114, enc_s(12'h008, 5'd4, 5'd0, 3'd2));
    put(32'h118, enc_i(12'h000, 5'd0, 3'd1, 5'd6, T_LOAD));
    put(32'h11C, enc_s(12'h00C, 5'd6, 5'd0, 3'd2));
    release_rst();
    wait_halt("ls");
    chk("sb_addr", st_addr[0], 32'h0000_0001);
    chk("sb_wstrb", {28'b0, st_strb[0]}, 32'h0000_0002);
    chk("sb_wdata", st_data[0], 32'hABAB_ABAB);
    chk("lb_value", st_data[1], 32'hFFFF_FF80);
    chk("sw_wstrb", {28'b0, st_strb[1]}, 32'h0000_000F);
    chk("lbu_value", st_data[2], 32'h0000_0080);
    chk("lh_value", st_data[3], 32'hFFFF_8000);
    chk("store_latency", ret_cyc[1] - ret_cyc[0], 32'd4);
    chk("load_latency", ret_cyc[2] - ret_cyc[1], 32'd5);

    // JAL to 0x20, taken BEQ back to 0x18, JALR x1,x5,3 to 0x42.
    begin_test();
    put(32'h100, enc_i(12'h040, 5'd0, 3'd0, 5'd5, T_OPI));
    put(32'h104, enc_j(21'h1F_FF1C, 5'd0));
    put(32'h020, enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0));
    put(32'h018, enc_i(12'h003, 5'd5, 3'd0, 5'd1, T_JALR));
    put(32'h040, enc_s(12'h000, 5'd1, 5'd0, 3'd2));
    release_rst();
    wait_halt("br");
    chk("jal_target", rd_log[2], 32'h0000_0020);
    chk("beq_target", rd_log[3], 32'h0000_0018);
    chk("beq_latency", ret_cyc[2] - ret_cyc[1], 32'd3);
    chk("jalr_fetch", rd_log[4], 32'h0000_0040);
    chk("jalr_link", st_data[0], 32'h0000_001C);
    chk("after_jalr_fetch", rd_log[5], 32'h0000_0044);
    chk("br_retires", n_ret, 32'd5);

    // Misaligned LW traps before any data request.
    begin_test();
    put(32'h100, enc_i(12'h002, 5'd0, 3'd0, 5'd1, T_OPI));
    put(32'h104, enc_i(12'h000, 5'd1, 3'd2, 5'd3, T_LOAD));
    release_rst();
    wait_halt("misalign");
    chk("misalign_trap", {30'b0, trap_cause}, 32'd2);
    chk("misalign_reads", n_rd, 32'd2);
    chk("misalign_stores", n_st, 32'd0);
    chk("misalign_retires", n_ret, 32'd1);

    // ECALL halts with cause 3 and does not retire.
    begin_test();
    put(32'h100, 32'h0000_0073);
    release_rst();
    wait_halt("ecall");
    chk("ecall_trap", {30'b0, trap_cause}, 32'd3);
    chk("ecall_retires", n_ret, 32'd0);

    // Bare illegal opcode 7'h7F at the reset vector.
    begin_test();
    release_rst();
    wait_halt("illegal");
    chk("illegal_trap", {30'b0, trap_cause}, 32'd1);
    chk("illegal_reads", n_rd, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
